// File: rtl/rx_word_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rx_word_buffer                                                  |
// | Purpose  : Receive-side FIFO with overflow accounting and sequence checker |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rx_word_buffer #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int STEP   = 2
) (
   input  logic              rclock,
   input  logic              reset,
   input  logic [WIDTH-1:0]  rxdata,
   input  logic              rxvalid,
   input  logic              clr,
   output logic [WIDTH-1:0]  rdata,
   output logic              rvalid,
   input  logic              rready,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              overflow,
   output logic [7:0]        drop_cnt,
   output logic              seq_err,
   output logic [7:0]        err_cnt
);

   localparam logic [ADDR_W:0]  c_depth = (ADDR_W+1)'(DEPTH);
   localparam logic [WIDTH-1:0] c_step  = WIDTH'(STEP);

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_level;
   logic              r_full;
   logic              r_rxvalid_d;
   logic              r_overflow;
   logic [7:0]        r_drop_cnt;
   logic              r_seq_err;
   logic [7:0]        r_err_cnt;
   logic              r_base_valid;
   logic [WIDTH-1:0]  r_last;

   logic              w_capture;
   logic              w_pop;
   logic              w_write;
   logic              w_drop;
   logic              w_mismatch;
   logic [ADDR_W:0]   w_level_nxt;

   always_comb begin
      w_capture   = rxvalid & ~r_rxvalid_d;
      w_pop       = (r_level != '0) & rready;
      w_write     = w_capture & (~r_full | w_pop);
      w_drop      = w_capture & r_full & ~w_pop;
      // A capture coinciding with clr only seeds the baseline, never checks it
      w_mismatch  = w_capture & r_base_valid & ~clr & (rxdata != r_last + c_step);
      w_level_nxt = r_level;
      if (w_write && !w_pop)
         w_level_nxt = r_level + 1'b1;
      else if (w_pop && !w_write)
         w_level_nxt = r_level - 1'b1;
   end

   always_ff @(posedge rclock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_full      <= 1'b0;
         r_rxvalid_d <= 1'b0;
      end else begin
         r_rxvalid_d <= rxvalid;
         if (w_write) begin
            r_mem[r_wr_ptr] <= rxdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == c_depth);
      end
   end

   always_ff @(posedge rclock or negedge reset) begin
      if (!reset) begin
         r_overflow   <= 1'b0;
         r_drop_cnt   <= '0;
         r_seq_err    <= 1'b0;
         r_err_cnt    <= '0;
         r_base_valid <= 1'b0;
         r_last       <= '0;
      end else begin
         r_seq_err <= w_mismatch;
         if (clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
         end else begin
            if (w_drop) begin
               r_overflow <= 1'b1;
               if (r_drop_cnt != 8'hFF)
                  r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_mismatch && r_err_cnt != 8'hFF)
               r_err_cnt <= r_err_cnt + 8'd1;
         end
         if (w_capture) begin
            r_last       <= rxdata;
            r_base_valid <= 1'b1;
         end else if (clr) begin
            r_base_valid <= 1'b0;
         end
      end
   end

   assign rdata    = r_mem[r_rd_ptr];
   assign rvalid   = (r_level != '0);
   assign level    = r_level;
   assign full     = r_full;
   assign overflow = r_overflow;
   assign drop_cnt = r_drop_cnt;
   assign seq_err  = r_seq_err;
   assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
